// File: rtl/bayer_mosaic_tx.sv
// bayer_mosaic_tx: RGB raster stream -> single-channel Bayer CFA stream.
// Row/column counters track the position of every accepted pixel, the CFA
// phase picks R, G or B, and one registered output stage presents the sample
// together with sof/eol/eof markers.
// Build option BAYER_MOSAIC_SKID_EN: a 2-entry skid buffer is inserted ahead
// of the output register, and in_ready then comes straight from a flop with
// no combinational path from out_ready.
//
// state    | meaning
// S_IDLE   | waiting for an in_sof pixel; pixels without sof are dropped
// S_ACTIVE | inside a frame; each accepted pixel advances row/col

module bayer_mosaic_tx #(
   parameter int pixelBitWidth = 12,
   parameter int IMG_WIDTH     = 640,
   parameter int IMG_HEIGHT    = 480,
   parameter int PATTERN       = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sof,
   input  logic [pixelBitWidth-1:0] in_r,
   input  logic [pixelBitWidth-1:0] in_g,
   input  logic [pixelBitWidth-1:0] in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [pixelBitWidth-1:0] out_pixel,
   output logic [1:0]               out_color,
   output logic                     out_sof,
   output logic                     out_eol,
   output logic                     out_eof,
   input  logic                     err_clr,
   output logic                     err_sof,
   output logic                     err_drop
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [1:0]    PAT_OFS  = 2'(PATTERN);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   typedef struct packed {
      logic [pixelBitWidth-1:0] pixel;
      logic [1:0]               color;
      logic                     sof;
      logic                     eol;
      logic                     eof;
   } sample_t;

   state_t          state;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   logic            accept;
   logic            emit;
   logic            ev_drop;
   logic            ev_sof;
   logic [CW-1:0]   pos_col;
   logic [RW-1:0]   pos_row;
   logic [1:0]      phase;
   sample_t         new_s;
   sample_t         out_q;
   logic            out_valid_q;

   assign accept  = in_valid & in_ready;
   assign ev_drop = accept & ~in_sof & (state == S_IDLE);
   assign ev_sof  = accept &  in_sof & (state == S_ACTIVE);
   assign emit    = accept & (in_sof | (state == S_ACTIVE));

   // A sof pixel always lands at (0,0), whatever the counters say.
   assign pos_col = in_sof ? '0 : col;
   assign pos_row = in_sof ? '0 : row;
   assign phase   = {pos_row[0], pos_col[0]} ^ PAT_OFS;

   // Build the CFA sample for the pixel currently offered at the input.
   always_comb begin
      new_s       = '0;
      new_s.color = phase;
      new_s.sof   = (pos_row == '0) && (pos_col == '0);
      new_s.eol   = (pos_col == COL_LAST);
      new_s.eof   = (pos_col == COL_LAST) && (pos_row == ROW_LAST);
      case (phase)
         2'b00:   new_s.pixel = in_r;
         2'b11:   new_s.pixel = in_b;
         default: new_s.pixel = in_g;
      endcase
   end

   // Frame FSM and position counters; counters return to 0 after the last pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         col   <= '0;
         row   <= '0;
      end else if (emit) begin
         if (pos_col == COL_LAST) begin
            col <= '0;
            if (pos_row == ROW_LAST) begin
               row   <= '0;
               state <= S_IDLE;
            end else begin
               row   <= pos_row + RW'(1);
               state <= S_ACTIVE;
            end
         end else begin
            col   <= pos_col + CW'(1);
            row   <= pos_row;
            state <= S_ACTIVE;
         end
      end
   end

   // Sticky error flags; a new error event in the clear cycle keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sof  <= 1'b0;
         err_drop <= 1'b0;
      end else begin
         if (err_clr) begin
            err_sof  <= 1'b0;
            err_drop <= 1'b0;
         end
         if (ev_sof) begin
            err_sof <= 1'b1;
         end
         if (ev_drop) begin
            err_drop <= 1'b1;
         end
      end
   end

`ifdef BAYER_MOSAIC_SKID_EN

   sample_t         skid_mem [2];
   logic            skid_rd;
   logic            skid_wr;
   logic [1:0]      skid_cnt;
   logic [1:0]      skid_cnt_nxt;
   logic            ready_q;
   logic            load;
   logic            pop;
   logic            push;

   assign in_ready = ready_q;

   // The output register reloads whenever it is empty or being consumed.
   // With an empty skid the new sample bypasses straight into it.
   assign load         = ~out_valid_q | out_ready;
   assign pop          = load & (skid_cnt != 2'd0);
   assign push         = emit & ~(load & (skid_cnt == 2'd0));
   assign skid_cnt_nxt = skid_cnt + {1'b0, push} - {1'b0, pop};

   // Skid storage; contents are don't-care while the entry is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         skid_mem[skid_wr] <= new_s;
      end
   end

   // Skid pointers, fill level and the registered ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_rd  <= 1'b0;
         skid_wr  <= 1'b0;
         skid_cnt <= 2'd0;
         ready_q  <= 1'b1;
      end else begin
         if (push) begin
            skid_wr <= ~skid_wr;
         end
         if (pop) begin
            skid_rd <= ~skid_rd;
         end
         skid_cnt <= skid_cnt_nxt;
         ready_q  <= (skid_cnt_nxt != 2'd2);
      end
   end

   // Output register: oldest skid entry first, otherwise the bypassed sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (load) begin
         if (skid_cnt != 2'd0) begin
            out_valid_q <= 1'b1;
            out_q       <= skid_mem[skid_rd];
         end else begin
            out_valid_q <= emit;
            if (emit) begin
               out_q <= new_s;
            end
         end
      end
   end

`else

   assign in_ready = ~out_valid_q | out_ready;

   // Single output register; holds its contents while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (in_ready) begin
         out_valid_q <= emit;
         if (emit) begin
            out_q <= new_s;
         end
      end
   end

`endif

   assign out_valid = out_valid_q;
   assign out_pixel = out_q.pixel;
   assign out_color = out_q.color;
   assign out_sof   = out_q.sof;
   assign out_eol   = out_q.eol;
   assign out_eof   = out_q.eof;

endmodule

// File: tb/tb_bayer_mosaic_tx.sv
// Testbench for bayer_mosaic_tx: a 4x2 frame through two instances (RGGB and
// BGGR), with a reference model filling scoreboard queues at every accept.

module tb_bayer_mosaic_tx;

   localparam int PW = 12;
   localparam int W  = 4;
   localparam int H  = 2;

   typedef struct packed {
      logic [PW-1:0] pix;
      logic [1:0]    col;
      logic          sof;
      logic          eol;
      logic          eof;
   } smp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic          out_ready = 1'b1;
   logic          err_clr = 1'b0;
   logic [PW-1:0] in_r = '0;
   logic [PW-1:0] in_g = '0;
   logic [PW-1:0] in_b = '0;

   logic          in_ready0, out_valid0, out_sof0, out_eol0, out_eof0, err_sof0, err_drop0;
   logic [PW-1:0] out_pixel0;
   logic [1:0]    out_color0;
   logic          in_ready3, out_valid3, out_sof3, out_eol3, out_eof3, err_sof3, err_drop3;
   logic [PW-1:0] out_pixel3;
   logic [1:0]    out_color3;

   smp_t q0[$];
   smp_t q3[$];
   smp_t obs0[$];
   smp_t obs3[$];

   int checks = 0;
   int errors = 0;
   int stall_cycles = 0;
   int xfers = 0;
   int m_active = 0;
   int m_row = 0;
   int m_col = 0;
   bit rand_en = 1'b0;

   logic [PW-1:0] tp_pix [8] = '{12'h100, 12'h201, 12'h102, 12'h203,
                                 12'h204, 12'h305, 12'h206, 12'h307};
   logic [1:0]    tp_col0 [8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
   logic [1:0]    tp_col3 [8] = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};

   bayer_mosaic_tx #(.pixelBitWidth(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PATTERN(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_sof(in_sof),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
      .out_pixel(out_pixel0), .out_color(out_color0), .out_sof(out_sof0), .out_eol(out_eol0),
      .out_eof(out_eof0), .err_clr(err_clr), .err_sof(err_sof0), .err_drop(err_drop0)
   );

   bayer_mosaic_tx #(.pixelBitWidth(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PATTERN(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_sof(in_sof),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid3), .out_ready(out_ready),
      .out_pixel(out_pixel3), .out_color(out_color3), .out_sof(out_sof3), .out_eol(out_eol3),
      .out_eof(out_eof3), .err_clr(err_clr), .err_sof(err_sof3), .err_drop(err_drop3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rand_en) begin
         #1 out_ready = ($urandom_range(0, 1) == 1);
      end
   end

   function automatic smp_t model(input int row, input int col, input int pat,
                                  input logic [PW-1:0] r, input logic [PW-1:0] g,
                                  input logic [PW-1:0] b);
      smp_t s;
      int   ph;
      ph    = ((row % 2) * 2 + (col % 2)) ^ pat;
      s.col = ph[1:0];
      s.pix = (ph == 0) ? r : ((ph == 3) ? b : g);
      s.sof = (row == 0) && (col == 0);
      s.eol = (col == W - 1);
      s.eof = (col == W - 1) && (row == H - 1);
      return s;
   endfunction

   // Scoreboard: a transfer is visible at the negedge before the edge that commits it.
   always @(negedge clk) begin : mon
      smp_t a;
      smp_t e;
      if (!rst && out_valid0 && out_ready) begin
         a = {out_pixel0, out_color0, out_sof0, out_eol0, out_eof0};
         obs0.push_back(a);
         xfers++;
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL sb_dut0_unexpected: got %h exp none", a);
         end else begin
            e = q0.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL sb_dut0: got pix=%h col=%0d sof/eol/eof=%b%b%b exp pix=%h col=%0d sof/eol/eof=%b%b%b",
                        a.pix, a.col, a.sof, a.eol, a.eof, e.pix, e.col, e.sof, e.eol, e.eof);
            end
         end
      end
      if (!rst && out_valid3 && out_ready) begin
         a = {out_pixel3, out_color3, out_sof3, out_eol3, out_eof3};
         obs3.push_back(a);
         checks++;
         if (q3.size() == 0) begin
            errors++;
            $display("FAIL sb_dut3_unexpected: got %h exp none", a);
         end else begin
            e = q3.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL sb_dut3: got pix=%h col=%0d sof/eol/eof=%b%b%b exp pix=%h col=%0d sof/eol/eof=%b%b%b",
                        a.pix, a.col, a.sof, a.eol, a.eof, e.pix, e.col, e.sof, e.eol, e.eof);
            end
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send_pixel(input logic [PW-1:0] r, input logic [PW-1:0] g,
                             input logic [PW-1:0] b, input logic sof);
      int waits = 0;
      in_r = r; in_g = g; in_b = b; in_sof = sof; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready0) break;
         waits++;
         if (waits > 200) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles exp 1", waits);
            break;
         end
      end
      if (in_ready0) begin
         if (m_active != 0 || sof) begin
            if (sof) begin
               m_row = 0;
               m_col = 0;
            end
            q0.push_back(model(m_row, m_col, 0, r, g, b));
            q3.push_back(model(m_row, m_col, 3, r, g, b));
            m_active = 1;
            if (m_col == W - 1) begin
               m_col = 0;
               if (m_row == H - 1) begin
                  m_row = 0;
                  m_active = 0;
               end else begin
                  m_row++;
               end
            end else begin
               m_col++;
            end
         end
      end
      stall_cycles += waits;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof = 1'b0;
   endtask

   task automatic send_frame(input int n, input int sof_at);
      for (int i = 0; i < n; i++) begin
         send_pixel(PW'(32'h100 + i), PW'(32'h200 + i), PW'(32'h300 + i),
                    (i == 0) || (i == sof_at));
      end
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 60; k++) begin
         if (q0.size() == 0 && q3.size() == 0) break;
         @(posedge clk);
      end
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({out_valid0, out_pixel0, out_color0, out_sof0, out_eol0, out_eof0, err_sof0, err_drop0, in_ready0}
          !== {1'b0, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_dut0: got v=%b pix=%h col=%0d flags=%b%b%b err=%b%b rdy=%b exp all 0 rdy=1",
                  out_valid0, out_pixel0, out_color0, out_sof0, out_eol0, out_eof0, err_sof0, err_drop0, in_ready0);
      end
      checks++;
      if ({out_valid3, out_pixel3, in_ready3} !== {1'b0, 12'h000, 1'b1}) begin
         errors++;
         $display("FAIL reset_dut3: got v=%b pix=%h rdy=%b exp 0 000 1", out_valid3, out_pixel3, in_ready3);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_basic();
      obs0.delete();
      obs3.delete();
      send_pixel(12'h100, 12'h200, 12'h300, 1'b1);
      @(negedge clk);
      checks++;
      if ({out_valid0, out_sof0} !== 2'b11) begin
         errors++;
         $display("FAIL latency: got valid/sof=%b%b exp 11", out_valid0, out_sof0);
      end
      @(posedge clk);
      #1;
      for (int i = 1; i < 8; i++) begin
         send_pixel(PW'(32'h100 + i), PW'(32'h200 + i), PW'(32'h300 + i), 1'b0);
      end
      wait_drain();
      checks++;
      if (q0.size() != 0 || obs0.size() != 8) begin
         errors++;
         $display("FAIL basic_count: got left=%0d seen=%0d exp 0 8", q0.size(), obs0.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs0[i].pix !== tp_pix[i] || obs0[i].col !== tp_col0[i] || obs3[i].col !== tp_col3[i]
                || obs0[i].eol !== (i == 3 || i == 7) || obs0[i].sof !== (i == 0) || obs0[i].eof !== (i == 7)) begin
               errors++;
               $display("FAIL basic_table[%0d]: got pix=%h col0=%0d col3=%0d exp pix=%h col0=%0d col3=%0d",
                        i, obs0[i].pix, obs0[i].col, obs3[i].col, tp_pix[i], tp_col0[i], tp_col3[i]);
            end
         end
         checks++;
         if (obs3[0].pix !== 12'h300) begin
            errors++;
            $display("FAIL bggr_first: got %h exp 300", obs3[0].pix);
         end
      end
   endtask

   task automatic test_drop();
      checks++;
      if (err_drop0 !== 1'b0) begin
         errors++;
         $display("FAIL drop_pre: got err_drop=%b exp 0", err_drop0);
      end
      for (int i = 0; i < 3; i++) begin
         send_pixel(12'hABC, 12'hABD, 12'hABE, 1'b0);
      end
      @(negedge clk);
      checks++;
      if ({err_drop0, err_drop3, err_sof0} !== 3'b110) begin
         errors++;
         $display("FAIL drop_flag: got drop0/drop3/sof=%b%b%b exp 110", err_drop0, err_drop3, err_sof0);
      end
      @(posedge clk);
      #1;
      obs0.delete();
      obs3.delete();
      send_frame(8, -1);
      wait_drain();
      checks++;
      if (obs0.size() != 8) begin
         errors++;
         $display("FAIL drop_count: got %0d exp 8", obs0.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs0[i].pix !== tp_pix[i]) begin
               errors++;
               $display("FAIL drop_table[%0d]: got %h exp %h", i, obs0[i].pix, tp_pix[i]);
            end
         end
      end
   endtask

   task automatic test_sof_restart();
      obs0.delete();
      obs3.delete();
      send_frame(13, 5);
      wait_drain();
      checks++;
      if (obs0.size() != 13) begin
         errors++;
         $display("FAIL restart_count: got %0d exp 13", obs0.size());
      end else begin
         checks++;
         if ({obs0[5].pix, obs0[5].col, obs0[5].sof} !== {12'h105, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL restart_pixel: got pix=%h col=%0d sof=%b exp 105 0 1",
                     obs0[5].pix, obs0[5].col, obs0[5].sof);
         end
      end
      checks++;
      if (err_sof0 !== 1'b1) begin
         errors++;
         $display("FAIL err_sof_set: got %b exp 1", err_sof0);
      end
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      @(negedge clk);
      checks++;
      if ({err_sof0, err_drop0} !== 2'b00) begin
         errors++;
         $display("FAIL err_clr: got sof/drop=%b%b exp 00", err_sof0, err_drop0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_clr_priority();
      err_clr = 1'b1;
      send_pixel(12'h011, 12'h022, 12'h033, 1'b0);
      err_clr = 1'b0;
      @(negedge clk);
      checks++;
      if (err_drop0 !== 1'b1) begin
         errors++;
         $display("FAIL clr_priority: got err_drop=%b exp 1", err_drop0);
      end
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
   endtask

   task automatic test_stall();
      smp_t snap;
      obs0.delete();
      obs3.delete();
      fork
         send_frame(8, -1);
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            snap = {out_pixel0, out_color0, out_sof0, out_eol0, out_eof0};
            checks++;
            if (out_valid0 !== 1'b1) begin
               errors++;
               $display("FAIL stall_valid: got %b exp 1", out_valid0);
            end
`ifndef BAYER_MOSAIC_SKID_EN
            checks++;
            if (in_ready0 !== 1'b0) begin
               errors++;
               $display("FAIL stall_ready: got %b exp 0", in_ready0);
            end
`endif
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if ({out_valid0, out_pixel0, out_color0, out_sof0, out_eol0, out_eof0} !== {1'b1, snap}) begin
               errors++;
               $display("FAIL stall_hold: got v=%b %h exp 1 %h", out_valid0,
                        {out_pixel0, out_color0, out_sof0, out_eol0, out_eof0}, snap);
            end
`ifndef BAYER_MOSAIC_SKID_EN
            checks++;
            if (in_ready0 !== 1'b0) begin
               errors++;
               $display("FAIL stall_ready2: got %b exp 0", in_ready0);
            end
`endif
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();
      checks++;
      if (obs0.size() != 8) begin
         errors++;
         $display("FAIL stall_count: got %0d exp 8", obs0.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs0[i].pix !== tp_pix[i]) begin
               errors++;
               $display("FAIL stall_order[%0d]: got %h exp %h", i, obs0[i].pix, tp_pix[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int base;
      base = xfers;
      stall_cycles = 0;
      send_frame(8, -1);
      send_frame(8, -1);
      wait_drain();
      checks++;
      if (stall_cycles != 0 || xfers - base != 16) begin
         errors++;
         $display("FAIL back_to_back: got stalls=%0d xfers=%0d exp 0 16", stall_cycles, xfers - base);
      end
   endtask

   task automatic test_random_ready();
      rand_en = 1'b1;
      send_frame(8, -1);
      send_frame(10, 3);
      send_frame(8, -1);
      rand_en = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      wait_drain();
      checks++;
      if (q0.size() != 0 || q3.size() != 0 || err_sof0 !== 1'b1) begin
         errors++;
         $display("FAIL random_ready: got left=%0d/%0d err_sof=%b exp 0/0 1", q0.size(), q3.size(), err_sof0);
      end
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_pixel(PW'(32'h100 + i), PW'(32'h200 + i), PW'(32'h300 + i), i == 0);
      end
      in_r = 12'h103; in_g = 12'h203; in_b = 12'h303; in_sof = 1'b0; in_valid = 1'b1;
      #3;
      checks++;
      if (out_valid0 !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_valid: got %b exp 1", out_valid0);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid0, out_valid3, in_ready0} !== 3'b001) begin
         errors++;
         $display("FAIL async_reset: got v0/v3/rdy=%b%b%b exp 001", out_valid0, out_valid3, in_ready0);
      end
      in_valid = 1'b0;
      q0.delete();
      q3.delete();
      m_active = 0;
      m_row = 0;
      m_col = 0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      obs0.delete();
      obs3.delete();
      send_frame(8, -1);
      wait_drain();
      checks++;
      if (obs0.size() != 8 || obs3.size() != 8) begin
         errors++;
         $display("FAIL reset_frame_count: got %0d/%0d exp 8/8", obs0.size(), obs3.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs0[i].pix !== tp_pix[i] || obs3[i].col !== tp_col3[i]) begin
               errors++;
               $display("FAIL reset_frame[%0d]: got pix=%h col3=%0d exp pix=%h col3=%0d",
                        i, obs0[i].pix, obs3[i].col, tp_pix[i], tp_col3[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_drop();
      test_sof_restart();
      test_clr_priority();
      test_stall();
      test_back_to_back();
      test_random_ready();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got time limit reached exp finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
